ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
// EX-stage multi-cycle multiply/divide unit. It consumes the operand values and MulDiv opcode
// that the ID/EX pipeline register presents to EX, and owns the architectural HI/LO registers.
// While an operation runs it raises EX_MD_Busy. Hazard control uses EX_MD_Busy to hold IF/ID
// and ID/EX, so the instruction stays in EX until the result is committed.
// PARAMETERS
// XLEN         32  operand width; HI/LO are XLEN each
// MUL_LATENCY  4   cycles spent in MUL state (>=1); models a pipelined multiplier
// PORTS
// sysclk         in   1     system clock, rising edge
// reset          in   1     asynchronous, active-low reset
// EX_Flush       in   1     synchronous abort/kill of EX instruction
// EX_MulDivOp    in   3     000 none,001 mult,010 multu,011 div,100 divu,101 mthi,110 mtlo,111 none
// EX_SrcA        in   XLEN  rs value after forwarding (multiplicand / dividend / mthi,mtlo data)
// EX_SrcB        in   XLEN  rt value after forwarding (multiplier / divisor)
// EX_MD_Busy     out  1     combinational stall request to hazard unit
// EX_MD_Done     out  1     registered 1-cycle pulse: HI/LO updated this cycle
// EX_MD_DivZero  out  1     registered 1-cycle pulse with Done for div/divu by zero
// EX_HI          out  XLEN  HI register (mfhi source)
// EX_LO          out  XLEN  LO register (mflo source)
// BEHAVIOUR
// - reset low (async): state=IDLE, HI=LO=0, counter=0, Done=DivZero=0, operand/partial regs=0.
// - States: IDLE, MUL, DIV, FIX, DONE.
// - IDLE:
//   - mult/multu: latch operands, go to MUL with cnt=MUL_LATENCY-1.
//   - div/divu with SrcB!=0: latch |A|,|B| (raw for divu) and sign info, go to DIV with cnt=XLEN-1.
//   - div/divu with SrcB==0: go straight to DONE with HI=SrcA, LO={XLEN{1}}, DivZero=1.
//   - mthi/mtlo: write HI/LO at the edge and stay in IDLE. No busy, no Done.
// - MUL: decrement cnt. At cnt==0, write {HI,LO} = 2*XLEN product and go to DONE.
//   - mult: signed x signed. multu: unsigned.
// - DIV: restoring radix-2, one quotient bit per cycle, MSB first. At cnt==0, go to FIX.
// - FIX: apply signs, write HI/LO, go to DONE.
//   - Quotient is negated if the operand signs differ.
//   - Remainder takes the dividend's sign.
//   - div 0x80000000/-1: LO=0x80000000, HI=0 (wraps, no trap).
// - DONE: Done=1 (and DivZero if applicable), Busy=0 so the pipeline advances.
//   - Always returns to IDLE. EX_MulDivOp is ignored here, so the same instruction never restarts.
// - EX_MD_Busy = (IDLE & op in mult..divu & ~EX_Flush) | MUL | DIV | FIX.
// - Latency (cycles with Busy=1):
//   - mult/multu: 1+MUL_LATENCY.
//   - div/divu: 1+XLEN+1.
//   - div by 0: 1.
//   - The DONE cycle always has Busy=0.
// - EX_Flush has priority over everything. In any state it forces IDLE at the next edge.
//   - HI/LO keep their values. Done and DivZero stay 0.
//   - In IDLE it suppresses start and mthi/mtlo.
// - Done and DivZero are 0 in every state except DONE.
// - HI/LO change only on: mthi/mtlo in IDLE, MUL completion, FIX, div-by-zero entry, reset.
// - Reset asserted mid-operation: immediate return to reset values. No partial result is written.
// TESTING
// - mult A=0xFFFFFFFF B=2 -> Busy high 5 cycles, Done on 6th, HI=0xFFFFFFFF LO=0xFFFFFFFE
// - multu A=0xFFFFFFFF B=2 -> HI=0x00000001 LO=0xFFFFFFFE, same timing
// - div A=-7 B=2 -> Busy 34 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF; divu 100/7 -> LO=14 HI=2
// - divu A=100 B=0 -> Busy 1 cycle, then DONE: HI=100 LO=0xFFFFFFFF, DivZero=Done=1 for 1 cycle
// - mthi 0x1234 -> HI=0x1234 next cycle, Busy never high; then div started, EX_Flush at busy
//   cycle 10 -> IDLE next edge, HI=0x1234 retained, no Done
// - reset low during MUL cycle 2 -> HI=LO=0, Busy=0 at once; op held in DONE never restarts

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle mult/div unit owning HI/LO; mult busy 1+MUL_LATENCY, div busy XLEN+2, div-by-zero busy 1.
// Holds the pipeline through combinational EX_MD_Busy; EX_Flush aborts any operation with no HI/LO update.
module ex_muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            EX_Flush,
  input  logic [2:0]      EX_MulDivOp,
  input  logic [XLEN-1:0] EX_SrcA,
  input  logic [XLEN-1:0] EX_SrcB,
  output logic            EX_MD_Busy,
  output logic            EX_MD_Done,
  output logic            EX_MD_DivZero,
  output logic [XLEN-1:0] EX_HI,
  output logic [XLEN-1:0] EX_LO
);

  localparam int CW = $clog2((XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY + 1);
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_INIT = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_opa;
  logic [XLEN-1:0] r_opb;
  logic [XLEN-1:0] r_rem;
  logic            r_sgn;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_done;
  logic            r_divzero;

  logic            w_op_mul;
  logic            w_op_div;
  logic            w_op_sgn;
  logic            w_op_mthi;
  logic            w_op_mtlo;
  logic            w_b_zero;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_op_mul  = (EX_MulDivOp == 3'b001) || (EX_MulDivOp == 3'b010);
  assign w_op_div  = (EX_MulDivOp == 3'b011) || (EX_MulDivOp == 3'b100);
  assign w_op_sgn  = (EX_MulDivOp == 3'b001) || (EX_MulDivOp == 3'b011);
  assign w_op_mthi = (EX_MulDivOp == 3'b101);
  assign w_op_mtlo = (EX_MulDivOp == 3'b110);
  assign w_b_zero  = (EX_SrcB == '0);
  assign w_abs_a   = (w_op_sgn && EX_SrcA[XLEN-1]) ? (~EX_SrcA + 1'b1) : EX_SrcA;
  assign w_abs_b   = (w_op_sgn && EX_SrcB[XLEN-1]) ? (~EX_SrcB + 1'b1) : EX_SrcB;

  // Sign-extend (or zero-extend for multu) so one unsigned 2*XLEN multiply covers both forms.
  logic [2*XLEN-1:0] w_mcand;
  logic [2*XLEN-1:0] w_mplier;
  logic [2*XLEN-1:0] w_prod;
  assign w_mcand  = {{XLEN{r_sgn & r_opa[XLEN-1]}}, r_opa};
  assign w_mplier = {{XLEN{r_sgn & r_opb[XLEN-1]}}, r_opb};
  assign w_prod   = w_mcand * w_mplier;

  // Restoring step: r_opa shifts the dividend out MSB-first while quotient bits shift in.
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_fix_q;
  logic [XLEN-1:0] w_fix_r;
  assign w_shift = {r_rem, r_opa[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_opb};
  assign w_fix_q = r_neg_q ? (~r_opa + 1'b1) : r_opa;
  assign w_fix_r = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_op_mul) begin
          w_state_nxt = S_MUL;
        end else if (w_op_div) begin
          w_state_nxt = w_b_zero ? S_DONE : S_DIV;
        end
      end
      S_MUL:   if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DIV:   if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (EX_Flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign EX_MD_Busy = ((r_state == S_IDLE) && (w_op_mul || w_op_div) && !EX_Flush) ||
                      (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_rem     <= '0;
      r_sgn     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done    <= (w_state_nxt == S_DONE);
      r_divzero <= (r_state == S_IDLE) && !EX_Flush && w_op_div && w_b_zero;
      if (!EX_Flush) begin
        case (r_state)
          S_IDLE: begin
            if (w_op_mthi) r_hi <= EX_SrcA;
            if (w_op_mtlo) r_lo <= EX_SrcA;
            if (w_op_mul) begin
              r_opa <= EX_SrcA;
              r_opb <= EX_SrcB;
              r_sgn <= w_op_sgn;
              r_cnt <= MUL_INIT;
            end else if (w_op_div) begin
              if (w_b_zero) begin
                r_hi <= EX_SrcA;
                r_lo <= '1;
              end else begin
                r_opa   <= w_abs_a;
                r_opb   <= w_abs_b;
                r_rem   <= '0;
                r_neg_q <= w_op_sgn && (EX_SrcA[XLEN-1] ^ EX_SrcB[XLEN-1]);
                r_neg_r <= w_op_sgn && EX_SrcA[XLEN-1];
                r_cnt   <= DIV_INIT;
              end
            end
          end
          S_MUL: begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              {r_hi, r_lo} <= w_prod;
            end
          end
          S_DIV: begin
            r_cnt <= r_cnt - 1'b1;
            r_opa <= {r_opa[XLEN-2:0], ~w_trial[XLEN]};
            r_rem <= w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
          end
          S_FIX: begin
            r_hi <= w_fix_r;
            r_lo <= w_fix_q;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign EX_MD_Done    = r_done;
  assign EX_MD_DivZero = r_divzero;
  assign EX_HI         = r_hi;
  assign EX_LO         = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized scoreboard bench for ex_muldiv_unit against a plain-arithmetic HI/LO reference model.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;
  localparam int ML   = 4;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic            sysclk = 1'b0;
  logic            reset = 1'b0;
  logic            EX_Flush = 1'b0;
  logic [2:0]      EX_MulDivOp = 3'd0;
  logic [XLEN-1:0] EX_SrcA = '0;
  logic [XLEN-1:0] EX_SrcB = '0;
  logic            EX_MD_Busy;
  logic            EX_MD_Done;
  logic            EX_MD_DivZero;
  logic [XLEN-1:0] EX_HI;
  logic [XLEN-1:0] EX_LO;

  ex_muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(ML)) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .EX_Flush      (EX_Flush),
    .EX_MulDivOp   (EX_MulDivOp),
    .EX_SrcA       (EX_SrcA),
    .EX_SrcB       (EX_SrcB),
    .EX_MD_Busy    (EX_MD_Busy),
    .EX_MD_Done    (EX_MD_Done),
    .EX_MD_DivZero (EX_MD_DivZero),
    .EX_HI         (EX_HI),
    .EX_LO         (EX_LO)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: computes the architectural result of one instruction and the Busy cycles it costs.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit done);
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    exp_t        e;
    lat  = 0;
    done = 1'b0;
    e.dz = 1'b0;
    case (op)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0]; lat = 1 + ML; done = 1'b1;
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; lat = 1 + ML; done = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        done = 1'b1;
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF; e.dz = 1'b1; lat = 1;
        end else begin
          lat = XLEN + 2;
          if (op == OP_DIV) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            m_lo = q[31:0]; m_hi = r[31:0];
          end else begin
            m_lo = a / b; m_hi = a % b;
          end
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: begin
      end
    endcase
    if (done) begin
      e.hi = m_hi;
      e.lo = m_lo;
      sb_q.push_back(e);
    end
  endtask

  // Presents one instruction, holds it while Busy, then retires it with a bubble cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    bit done;
    int busy_n;
    model(op, a, b, lat, done);
    @(negedge sysclk);
    EX_MulDivOp = op; EX_SrcA = a; EX_SrcB = b;
    busy_n = 0;
    #1;
    while (EX_MD_Busy && busy_n < 100) begin
      busy_n++;
      @(negedge sysclk);
      #1;
    end
    check("busy_cycles", 64'(busy_n), 64'(lat));
    check("done_at_release", {63'b0, EX_MD_Done}, {63'b0, done});
    @(negedge sysclk);
    EX_MulDivOp = OP_NONE;
    #1;
    check("hi_after", {32'b0, EX_HI}, {32'b0, m_hi});
    check("lo_after", {32'b0, EX_LO}, {32'b0, m_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: every Done pulse consumes the oldest expected result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (EX_MD_Done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got Done=1 expected no pending result (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("done_hi", {32'b0, EX_HI}, {32'b0, e.hi});
          check("done_lo", {32'b0, EX_LO}, {32'b0, e.lo});
          check("done_divzero", {63'b0, EX_MD_DivZero}, {63'b0, e.dz});
        end
      end else if (EX_MD_DivZero) begin
        n_checks++;
        n_errors++;
        $display("FAIL divzero_without_done: got DivZero=1 expected 0 (t=%0t)", $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check("rst_hi", {32'b0, EX_HI}, 64'd0);
    check("rst_lo", {32'b0, EX_LO}, 64'd0);
    check("rst_busy", {63'b0, EX_MD_Busy}, 64'd0);
    check("rst_done", {63'b0, EX_MD_Done}, 64'd0);
    check("rst_divzero", {63'b0, EX_MD_DivZero}, 64'd0);
    repeat (2) @(negedge sysclk);
    reset = 1'b1;

    issue(OP_MULT,  32'hFFFF_FFFF, 32'd2);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(OP_DIVU,  32'd100, 32'd7);
    issue(OP_DIVU,  32'd100, 32'd0);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_DIV,   32'd7, 32'hFFFF_FFFE);
    issue(OP_MTLO,  32'hCAFE_0001, 32'd0);
    issue(OP_MTHI,  32'h0000_1234, 32'd0);

    // Flush a running divide on its 10th busy cycle.
    @(negedge sysclk);
    EX_MulDivOp = OP_DIV; EX_SrcA = 32'd1000; EX_SrcB = 32'd3;
    repeat (9) @(negedge sysclk);
    #1;
    check("flush_busy_before", {63'b0, EX_MD_Busy}, 64'd1);
    EX_Flush = 1'b1;
    @(negedge sysclk);
    EX_Flush = 1'b0;
    EX_MulDivOp = OP_NONE;
    #1;
    check("flush_busy_after", {63'b0, EX_MD_Busy}, 64'd0);
    check("flush_done", {63'b0, EX_MD_Done}, 64'd0);
    check("flush_hi_kept", {32'b0, EX_HI}, 64'h1234);
    check("flush_lo_kept", {32'b0, EX_LO}, {32'b0, m_lo});
    repeat (40) @(negedge sysclk);
    #1;
    check("flush_still_idle", {63'b0, EX_MD_Busy}, 64'd0);

    // Flush in IDLE suppresses both a start and a mthi.
    @(negedge sysclk);
    EX_MulDivOp = OP_MTHI; EX_SrcA = 32'hDEAD_BEEF; EX_Flush = 1'b1;
    #1;
    check("idleflush_mthi_busy", {63'b0, EX_MD_Busy}, 64'd0);
    @(negedge sysclk);
    EX_MulDivOp = OP_MULT; EX_SrcA = 32'd3; EX_SrcB = 32'd5;
    #1;
    check("idleflush_hi", {32'b0, EX_HI}, {32'b0, m_hi});
    check("idleflush_mult_busy", {63'b0, EX_MD_Busy}, 64'd0);
    @(negedge sysclk);
    EX_Flush = 1'b0;
    EX_MulDivOp = OP_NONE;
    #1;
    check("idleflush_no_start", {63'b0, EX_MD_Busy}, 64'd0);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end

    // Asynchronous reset in the second MUL cycle.
    issue(OP_MTHI, 32'h5555_AAAA, 32'd0);
    @(negedge sysclk);
    EX_MulDivOp = OP_MULTU; EX_SrcA = 32'd12345; EX_SrcB = 32'd678;
    repeat (2) @(negedge sysclk);
    #2;
    reset = 1'b0;
    EX_MulDivOp = OP_NONE;
    m_hi = '0;
    m_lo = '0;
    #1;
    check("midrst_hi", {32'b0, EX_HI}, 64'd0);
    check("midrst_lo", {32'b0, EX_LO}, 64'd0);
    check("midrst_busy", {63'b0, EX_MD_Busy}, 64'd0);
    check("midrst_done", {63'b0, EX_MD_Done}, 64'd0);
    @(negedge sysclk);
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    #1;
    check("postrst_busy", {63'b0, EX_MD_Busy}, 64'd0);
    issue(OP_MULTU, 32'd6, 32'd7);

    repeat (3) @(negedge sysclk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
